// File: rtl/stdp_array.sv
// stdp_array: multi-synapse STDP engine for one postsynaptic neuron.
//
// Each presynaptic channel and the postsynaptic neuron keep a spike-age counter
// that advances on every time-step tick. A tick carrying any spike, arriving
// while the engine is idle, starts a scan. The scan visits one channel per
// cycle and applies a two-segment piecewise-linear STDP curve to that channel's
// weight. The result is clamped to [W_MIN, W_MAX].
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tick              one-cycle time-step strobe
//   pre_spike         presynaptic spikes (sampled on tick)
//   post_spike        postsynaptic spike (sampled on tick)
//   m1, b1, m2, b2    slope/intercept of the two curve segments (signed Q)
//   brk               segment breakpoint in ticks
//   wr_en/addr/data   host weight write (idle only, stored unclamped)
//   rd_addr, rd_data  combinational weight read
//   busy              scan in progress
//   done              one-cycle pulse when a scan completes
//   overrun           sticky: a tick arrived while scanning / finishing
module stdp_array #(
    parameter int                    N       = 32,
    parameter int                    Q       = 16,
    parameter int                    NUM_SYN = 8,
    parameter int                    T_W     = 8,
    parameter logic signed [N-1:0]   W_INIT  = 32'sh0002_0000,
    parameter logic signed [N-1:0]   W_MIN   = 32'sh0000_0000,
    parameter logic signed [N-1:0]   W_MAX   = 32'sh0004_0000,
    localparam int                   AW      = $clog2(NUM_SYN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [NUM_SYN-1:0]  pre_spike,
    input  logic                post_spike,
    input  logic [N-1:0]        m1,
    input  logic [N-1:0]        b1,
    input  logic [N-1:0]        m2,
    input  logic [N-1:0]        b2,
    input  logic [T_W-1:0]      brk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [N-1:0]        wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [N-1:0]        rd_data,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    // Parameter sanity: the fractional point must sit inside the word and the
    // dt*slope product must fit the double-width product register.
    if (Q >= N || T_W >= N || NUM_SYN < 2) begin : g_bad_params
        $error("stdp_array: illegal parameter combination");
    end

    localparam logic [T_W-1:0]        T_MAX    = {T_W{1'b1}};
    localparam logic [T_W-1:0]        AGE_ONE  = {{(T_W-1){1'b0}}, 1'b1};
    localparam logic [T_W-1:0]        AGE_ZERO = {T_W{1'b0}};
    localparam logic [AW-1:0]         LAST_IDX = AW'(NUM_SYN - 1);
    localparam logic [AW-1:0]         IDX_ONE  = AW'(1);
    localparam logic signed [N-1:0]   S_MAX    = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]   S_ZERO   = {N{1'b0}};
    localparam logic signed [2*N-1:0] P_MAX    = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] P_MIN    = {{(N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [N:0]     W_MIN_X  = {W_MIN[N-1], W_MIN};
    localparam logic signed [N:0]     W_MAX_X  = {W_MAX[N-1], W_MAX};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Saturate a double-width product back to the N-bit signed range.
    function automatic logic signed [N-1:0] sat_n(input logic signed [2*N-1:0] v);
        logic signed [N-1:0] r;
        if (v > P_MAX) begin
            r = S_MAX;
        end else if (v < P_MIN) begin
            r = {1'b1, {(N-1){1'b0}}};
        end else begin
            r = v[N-1:0];
        end
        return r;
    endfunction

    // STDP magnitude b - m*dt for the segment selected by dt vs brk, floored at 0.
    function automatic logic signed [N-1:0] stdp_mag(
        input logic [T_W-1:0]      dt,
        input logic [T_W-1:0]      brk_v,
        input logic signed [N-1:0] m1_v,
        input logic signed [N-1:0] b1_v,
        input logic signed [N-1:0] m2_v,
        input logic signed [N-1:0] b2_v
    );
        logic signed [N-1:0]   m_v;
        logic signed [N-1:0]   b_v;
        logic signed [N-1:0]   p_sat;
        logic signed [2*N-1:0] prod;
        logic signed [N:0]     diff;
        logic signed [N-1:0]   r;
        if (dt < brk_v) begin
            m_v = m1_v;
            b_v = b1_v;
        end else begin
            m_v = m2_v;
            b_v = b2_v;
        end
        // dt is a plain integer count, so zero-extend it into the product.
        prod  = $signed({{N{m_v[N-1]}}, m_v}) * $signed({{(2*N-T_W){1'b0}}, dt});
        p_sat = sat_n(prod);
        diff  = $signed({b_v[N-1], b_v}) - $signed({p_sat[N-1], p_sat});
        if (diff[N]) begin
            r = S_ZERO;
        end else if (diff[N-1]) begin
            r = S_MAX;
        end else begin
            r = diff[N-1:0];
        end
        return r;
    endfunction

    // Apply +/-mag at N+1 bits and clamp into the legal weight range.
    function automatic logic signed [N-1:0] upd_w(
        input logic signed [N-1:0] w,
        input logic signed [N-1:0] mag,
        input logic                dep
    );
        logic signed [N:0]   sum;
        logic signed [N-1:0] r;
        if (dep) begin
            sum = $signed({w[N-1], w}) - $signed({mag[N-1], mag});
        end else begin
            sum = $signed({w[N-1], w}) + $signed({mag[N-1], mag});
        end
        if (sum < W_MIN_X) begin
            r = W_MIN;
        end else if (sum > W_MAX_X) begin
            r = W_MAX;
        end else begin
            r = sum[N-1:0];
        end
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [AW-1:0]           idx_r;
    logic [AW-1:0]           idx_nx_s;
    logic [T_W-1:0]          age_pre_r     [NUM_SYN];
    logic [T_W-1:0]          age_post_r;
    logic [T_W-1:0]          dt_pre_s      [NUM_SYN];
    logic [T_W-1:0]          dt_post_s;
    logic [T_W-1:0]          snap_pre_r    [NUM_SYN];
    logic [T_W-1:0]          snap_post_r;
    logic [NUM_SYN-1:0]      lat_pre_r;
    logic                    lat_post_r;
    logic signed [N-1:0]     weight_r      [NUM_SYN];
    logic                    busy_r;
    logic                    done_r;
    logic                    overrun_r;
    logic                    start_s;
    logic                    do_pot_s;
    logic                    do_dep_s;
    logic [T_W-1:0]          dt_use_s;
    logic signed [N-1:0]     mag_s;
    logic signed [N-1:0]     new_w_s;

    // Saturating next-age values; T_MAX sticks as "no history".
    always_comb begin
        for (int i = 0; i < NUM_SYN; i++) begin
            dt_pre_s[i] = (age_pre_r[i] == T_MAX) ? T_MAX : age_pre_r[i] + AGE_ONE;
        end
        dt_post_s = (age_post_r == T_MAX) ? T_MAX : age_post_r + AGE_ONE;
    end

    assign start_s = tick && (state_r == ST_IDLE) && ((|pre_spike) || post_spike);

    // Age counters advance on every tick, independent of the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                age_pre_r[i] <= T_MAX;
            end
            age_post_r <= T_MAX;
        end else if (tick) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                age_pre_r[i] <= pre_spike[i] ? AGE_ZERO : dt_pre_s[i];
            end
            age_post_r <= post_spike ? AGE_ZERO : dt_post_s;
        end
    end

    // Capture the starting tick's spikes and pre-update dt values for the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                snap_pre_r[i] <= T_MAX;
            end
            snap_post_r <= T_MAX;
            lat_pre_r   <= {NUM_SYN{1'b0}};
            lat_post_r  <= 1'b0;
        end else if (start_s) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                snap_pre_r[i] <= dt_pre_s[i];
            end
            snap_post_r <= dt_post_s;
            lat_pre_r   <= pre_spike;
            lat_post_r  <= post_spike;
        end
    end

    // Per-channel rule for the channel under the scan index; first match wins.
    always_comb begin
        do_pot_s = 1'b0;
        do_dep_s = 1'b0;
        dt_use_s = AGE_ZERO;
        if (lat_pre_r[idx_r] && lat_post_r) begin
            do_pot_s = 1'b1;
            dt_use_s = AGE_ZERO;
        end else if (lat_post_r && (snap_pre_r[idx_r] != T_MAX)) begin
            do_pot_s = 1'b1;
            dt_use_s = snap_pre_r[idx_r];
        end else if (lat_pre_r[idx_r] && (snap_post_r != T_MAX)) begin
            do_dep_s = 1'b1;
            dt_use_s = snap_post_r;
        end else begin
            do_pot_s = 1'b0;
            do_dep_s = 1'b0;
        end
    end

    // Magnitude and clamped candidate weight for the current channel.
    always_comb begin
        mag_s   = stdp_mag(dt_use_s, brk, $signed(m1), $signed(b1), $signed(m2), $signed(b2));
        new_w_s = weight_r[idx_r];
        if (do_pot_s || do_dep_s) begin
            new_w_s = upd_w(weight_r[idx_r], mag_s, do_dep_s);
        end else begin
            new_w_s = weight_r[idx_r];
        end
    end

    // Next-state logic: IDLE -> SCAN (NUM_SYN cycles) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_SCAN;
                    idx_nx_s   = {AW{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_nx_s = ST_DONE;
                end else begin
                    idx_nx_s = idx_r + IDX_ONE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = {AW{1'b0}};
            end
        endcase
    end

    // State, scan index and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= {AW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            busy_r  <= (state_nx_s == ST_SCAN);
            done_r  <= (state_nx_s == ST_DONE);
            // Any tick outside IDLE is lost to the scanner; flag it until reset.
            if (tick && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Weight file: scan writes one channel per cycle; host writes only when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                weight_r[i] <= W_INIT;
            end
        end else if (state_r == ST_SCAN) begin
            weight_r[idx_r] <= new_w_s;
        end else if ((state_r == ST_IDLE) && wr_en) begin
            weight_r[wr_addr] <= $signed(wr_data);
        end
    end

    assign rd_data = weight_r[rd_addr];
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_stdp_array.sv
// Directed bench for stdp_array with a scoreboard queue of expected weights.
module tb_stdp_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [7:0]  pre_spike;
    logic        post_spike;
    logic [31:0] m1, b1, m2, b2;
    logic [7:0]  brk;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        overrun;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] WI = 32'h0002_0000;

    stdp_array dut (
        .clk(clk), .rst(rst), .tick(tick), .pre_spike(pre_spike),
        .post_spike(post_spike), .m1(m1), .b1(b1), .m2(m2), .b2(b2),
        .brk(brk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push a full expected weight image: all channels W_INIT except the given overrides.
    task automatic push_image(input logic [7:0] mask, input logic [31:0] v0, input logic [31:0] v1,
                              input logic [2:0] c0, input logic [2:0] c1);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.ch  = 3'(i);
            e.val = WI;
            if (mask[0] && c0 == 3'(i)) e.val = v0;
            if (mask[1] && c1 == 3'(i)) e.val = v1;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step();
            rd_addr = e.ch;
            #1;
            chk($sformatf("%s_w%0d", tag, e.ch), rd_data, e.val);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Drive one tick; for a spiking tick wait (bounded) for done and return the latency.
    task automatic tick_spk(input logic [7:0] pre, input logic post, output int lat);
        tick = 1'b1;
        pre_spike = pre;
        post_spike = post;
        step();
        tick = 1'b0;
        pre_spike = 8'h00;
        post_spike = 1'b0;
        lat = 0;
        if (pre != 8'h00 || post) begin
            lat = 1;
            while (!done && lat < 40) begin
                step();
                lat++;
            end
            step();
        end else begin
            step();
        end
    endtask

    initial begin
        int lat;
        int k;
        rst = 1'b0; tick = 1'b0; pre_spike = 8'h00; post_spike = 1'b0;
        m1 = 32'h0000_1000; b1 = 32'h0001_0000; m2 = 32'h0000_0800; b2 = 32'h0000_8000;
        brk = 8'd8; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'h0; rd_addr = 3'd0;

        // Reset state
        do_reset();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        push_image(8'h00, WI, WI, 3'd0, 3'd0);
        drain("rst");

        // Causal: pre[0] then post three ticks later -> dt=3, mag=0xD000
        tick_spk(8'h01, 1'b0, lat);
        chk("causal_lat_first", 32'(lat), 32'd9);
        tick_spk(8'h00, 1'b0, lat);
        tick_spk(8'h00, 1'b0, lat);
        tick_spk(8'h00, 1'b1, lat);
        chk("causal_lat", 32'(lat), 32'd9);
        chk("causal_overrun", {31'b0, overrun}, 32'd0);
        push_image(8'h01, 32'h0002_D000, WI, 3'd0, 3'd0);
        drain("causal");

        // Anti-causal on segment 2: dt_post=10 -> mag=0x3000, depress
        do_reset();
        tick_spk(8'h00, 1'b1, lat);
        for (int i = 0; i < 9; i++) tick_spk(8'h00, 1'b0, lat);
        tick_spk(8'h02, 1'b0, lat);
        push_image(8'h01, 32'h0001_D000, WI, 3'd1, 3'd0);
        drain("anti");

        // Clamp at W_MAX after an idle host write
        do_reset();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0003_F000;
        step();
        wr_en = 1'b0;
        tick_spk(8'h04, 1'b0, lat);
        tick_spk(8'h00, 1'b1, lat);
        push_image(8'h01, 32'h0004_0000, WI, 3'd2, 3'd0);
        drain("clamp");

        // Simultaneous pre[3] and post: dt=0 -> mag=b1
        do_reset();
        tick_spk(8'h08, 1'b1, lat);
        push_image(8'h01, 32'h0003_0000, WI, 3'd3, 3'd0);
        drain("simul");

        // Negative magnitude clipped to zero: dt_post=20
        do_reset();
        tick_spk(8'h00, 1'b1, lat);
        for (int i = 0; i < 19; i++) tick_spk(8'h00, 1'b0, lat);
        tick_spk(8'h10, 1'b0, lat);
        push_image(8'h00, WI, WI, 3'd0, 3'd0);
        drain("negmag");

        // Overrun: second spiking tick two cycles after the first, plus a busy host write
        do_reset();
        tick = 1'b1; pre_spike = 8'h20;
        step();
        tick = 1'b0; pre_spike = 8'h00;
        chk("ovr_busy", {31'b0, busy}, 32'd1);
        step();
        tick = 1'b1; post_spike = 1'b1;
        step();
        tick = 1'b0; post_spike = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h0001_1111;
        step();
        wr_en = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            step();
            k++;
        end
        chk("ovr_done_seen", {31'b0, done}, 32'd1);
        chk("ovr_flag", {31'b0, overrun}, 32'd1);
        step();
        // Post age from the dropped tick is 0, so this depresses ch6 with dt=1
        tick_spk(8'h40, 1'b0, lat);
        chk("ovr_sticky", {31'b0, overrun}, 32'd1);
        push_image(8'h01, 32'h0001_1000, WI, 3'd6, 3'd0);
        drain("ovr");

        // Reset in scan cycle 3 aborts the scan and restores every weight
        do_reset();
        tick = 1'b1; pre_spike = 8'h01; post_spike = 1'b1;
        step();
        tick = 1'b0; pre_spike = 8'h00; post_spike = 1'b0;
        step();
        step();
        step();
        rd_addr = 3'd0;
        #1;
        chk("mid_w0_before", rd_data, 32'h0003_0000);
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy_after", {31'b0, busy}, 32'd0);
        chk("mid_w0_after", rd_data, WI);
        step();
        rst = 1'b0;
        step();
        chk("mid_overrun", {31'b0, overrun}, 32'd0);
        push_image(8'h00, WI, WI, 3'd0, 3'd0);
        drain("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stdp_array.md
Name: stdp_array

Overview:
- Multi-synapse STDP engine for one postsynaptic Izhikevich neuron with NUM_SYN presynaptic inputs.
- Tracks per-channel spike ages and holds a weight register file.
- On each time-step tick carrying spikes, scans the channels one per cycle. Each weight is updated with a programmable two-segment piecewise-linear STDP curve, then clamped to a bounded range.
- Sits between the neuron cores and the synaptic current accumulator.

Parameters:
N, 32, fixed-point word width (signed)
Q, 16, fractional bits
NUM_SYN, 8, presynaptic channel count (>=2)
T_W, 8, age counter width; T_MAX = 2^T_W-1 means "no history"
W_INIT, 32'h0002_0000, reset weight (2.0)
W_MIN, 32'h0000_0000, lower weight clamp
W_MAX, 32'h0004_0000, upper weight clamp (4.0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
tick  in  1  one-cycle time-step strobe
pre_spike  in  NUM_SYN  presynaptic spikes, sampled only when tick=1
post_spike  in  1  postsynaptic spike, sampled only when tick=1
m1, b1  in  N  segment-1 slope/intercept (dt < brk)
m2, b2  in  N  segment-2 slope/intercept (dt >= brk)
brk  in  T_W  segment breakpoint in ticks
wr_en  in  1  host weight write
wr_addr  in  clog2(NUM_SYN)  write channel
wr_data  in  N  write value (stored unclamped)
rd_addr  in  clog2(NUM_SYN)  read channel
rd_data  out  N  combinational weight[rd_addr]
busy  out  1  scan in progress
done  out  1  one-cycle pulse at end of scan
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, immediate):
  - weights = W_INIT; all ages = T_MAX.
  - busy, done, overrun = 0; FSM -> IDLE.
  - A reset mid-scan aborts the scan; no partial update survives.
- Age tracking, on every tick regardless of FSM state:
  - dt_x = min(age_x + 1, T_MAX).
  - age_x <= 0 if channel x spiked on this tick, else dt_x.
  - The post age is tracked identically.
- FSM IDLE -> SCAN, on a tick with any spike while IDLE:
  - Latch pre_spike and post_spike.
  - Snapshot pre-update dt for all channels and for post.
  - busy=1 from the next cycle.
- SCAN:
  - Index i runs 0..NUM_SYN-1, one channel per cycle; weight[i] is written at the end of scan cycle i.
  - After i = NUM_SYN-1 -> DONE. DONE lasts one cycle with done=1, busy=0, then IDLE.
- Latency: tick at cycle T; channel i written at the edge ending cycle T+1+i; done high in cycle T+NUM_SYN+1.
- Per-channel rule, first match wins:
  - pre[i] and post on the same tick: potentiate with dt=0.
  - post only, and dt_pre[i] != T_MAX: potentiate with dt_pre[i].
  - pre[i] only, and dt_post != T_MAX: depress with dt_post.
  - Otherwise: no change.
- Magnitude (signed Q-format):
  - mag = b1 - m1*dt if dt < brk, else b2 - m2*dt.
  - The product is formed at 2N bits with dt as an integer, then saturated to N bits.
  - If mag < 0, mag = 0.
- Weight update:
  - new = w + mag (potentiate) or w - mag (depress), computed at N+1 bits.
  - Clamp to [W_MIN, W_MAX].
- Host write: accepted only when busy=0 and not in DONE; ignored otherwise.
- Tick while busy or in DONE:
  - overrun <= 1 (cleared only by rst).
  - That tick's spikes are dropped from scanning.
  - Ages still update.

Test Plan:
Common setup: Q=16, m1=0x1000, b1=0x10000, m2=0x0800, b2=0x8000, brk=8.
- Causal: pre[0] on tick k, post on tick k+3 -> dt=3, mag=0x D000; weight0 = 0x0002_D000; channels 1..7 stay 0x0002_0000; done 9 cycles after tick.
- Anti-causal segment 2: post on tick k, pre[1] on tick k+10 -> mag=0x3000; weight1 = 0x0001_D000.
- Clamp: write weight2=0x0003_F000; pre[2] then post one tick later (mag=0xF000) -> weight2 = 0x0004_0000.
- Simultaneous: pre[3] and post on the same tick -> weight3 = 0x0003_0000.
- Negative mag: post, then pre[4] 20 ticks later -> mag clipped to 0; weight4 unchanged.
- Overrun: second spiking tick 2 cycles after the first -> overrun=1; only the first tick's updates applied; ages reflect both ticks.
- Reset mid-scan: assert rst in scan cycle 3 -> busy=0 immediately; all weights = 0x0002_0000.
